// File: rtl/cache_bus_pkg.sv
// Cache bus request/response structures shared by initiators and targets.
package cache_bus_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic        burst;
        logic        cached;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  data_strobe;
        logic        data_ok;
        logic        data_last;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] r_data;
        logic        data_ok;
        logic        data_last;
    } cache_bus_resp_t;

endpackage

// File: rtl/cache_bus_sram_responder.sv
// On-chip SRAM target for the cache bus. Accepts one request at a time, waits a
// fixed latency, then serves single-word or wrapping 4-beat line transfers,
// reads or byte-strobed writes, paced by the initiator's data_ok.
// Optional build macro CBUS_SRAM_BEAT_STALL_EN: an 8-bit LFSR inserts random
// beat bubbles during data phases to exercise initiator bubble tolerance.
module cache_bus_sram_responder
    import cache_bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  cache_bus_req_t  bus_req_i,
    output cache_bus_resp_t bus_resp_o
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam int unsigned CntW = $clog2(BURST_LEN) + 1;
    localparam int unsigned LatW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StLat  = 4'b0010,
        StRd   = 4'b0100,
        StWr   = 4'b1000
    } state_e;

    state_e            state_q, state_d;
    logic [31:2]       addr_q, addr_d;
    logic              write_q, write_d;
    logic              burst_q, burst_d;
    logic [CntW-1:0]   last_idx_q, last_idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LatW-1:0]   lat_q, lat_d;

    logic [31:0]       mem_q [MEM_WORDS];

    logic [29:0]       beat_word;
    logic [AW-1:0]     mem_idx;
    logic              data_phase;
    logic              beat_fire;
    logic              last_beat;
    logic              stall;

`ifdef CBUS_SRAM_BEAT_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // LFSR (taps 8,6,5,4) advances only while a data phase is in progress
    always_comb begin
        lfsr_d = lfsr_q;
        if (data_phase) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // LFSR register, reseeded on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Beat addressing: bursts wrap inside the 16 B line
    always_comb begin
        if (burst_q) begin
            beat_word = {addr_q[31:4], addr_q[3:2] + cnt_q[1:0]};
        end else begin
            beat_word = addr_q[31:2];
        end
        mem_idx    = beat_word[AW-1:0];
        data_phase = (state_q == StRd) || (state_q == StWr);
        beat_fire  = data_phase && bus_req_i.data_ok && !stall;
        last_beat  = (cnt_q == last_idx_q);
    end

    // Next-state logic for transfer sequencing
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        burst_d    = burst_q;
        last_idx_d = last_idx_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        unique case (state_q)
            StIdle: begin
                if (bus_req_i.valid) begin
                    addr_d     = bus_req_i.addr[31:2];
                    write_d    = bus_req_i.write;
                    burst_d    = bus_req_i.burst;
                    last_idx_d = bus_req_i.burst ? CntW'(BURST_LEN - 1) : '0;
                    cnt_d      = '0;
                    lat_d      = '0;
                    if (LATENCY > 0) begin
                        state_d = StLat;
                    end else begin
                        state_d = bus_req_i.write ? StWr : StRd;
                    end
                end
            end
            StLat: begin
                if (lat_q == LatW'(LATENCY - 1)) begin
                    state_d = write_q ? StWr : StRd;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StRd, StWr: begin
                if (beat_fire) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control registers; reset abandons any transfer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            write_q    <= 1'b0;
            burst_q    <= 1'b0;
            last_idx_q <= '0;
            cnt_q      <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            burst_q    <= burst_d;
            last_idx_q <= last_idx_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
        end
    end

    // Byte-strobed write on an accepted write beat; storage is never cleared
    always_ff @(posedge clk) begin
        if (beat_fire && (state_q == StWr)) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_req_i.data_strobe[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= bus_req_i.w_data[8*i +: 8];
                end
            end
        end
    end

    // Response outputs; forced to zero while reset is asserted
    always_comb begin
        bus_resp_o = '0;
        if (!rst) begin
            bus_resp_o.ready     = (state_q == StIdle);
            bus_resp_o.data_ok   = beat_fire;
            bus_resp_o.data_last = beat_fire && last_beat;
            if (beat_fire && (state_q == StRd)) begin
                bus_resp_o.r_data = mem_q[mem_idx];
            end
        end
    end

    // Completion is counted locally, so initiator data_last and cached are unused
    logic unused_ok;
    assign unused_ok = ^{bus_req_i.cached, bus_req_i.data_last, beat_word[29:AW]};

endmodule
